// File: rtl/ascii_score_parser.sv
// Parses a CR-terminated decimal entry of up to MAX_DIGITS ASCII digits into a binary score.
// Optional backspace editing is enabled by defining ASCII_SCORE_PARSER_BACKSPACE_EN.
module ascii_score_parser #(
  parameter int unsigned MAX_DIGITS = 3,
  parameter int unsigned SCORE_W    = 10
) (
  input  logic               pclk,
  input  logic               rst_n,
  input  logic               char_valid,
  input  logic [6:0]         char_code,
  output logic               char_ready,
  output logic [SCORE_W-1:0] score,
  output logic               score_valid,
  output logic               parse_err,
  output logic [1:0]         digit_count
);

  typedef enum logic [1:0] {IDLE, ACCUM, DONE, ERR} state_e;

  localparam logic [6:0] CHAR_0  = 7'd48;
  localparam logic [6:0] CHAR_9  = 7'd57;
  localparam logic [6:0] CHAR_CR = 7'd13;
`ifdef ASCII_SCORE_PARSER_BACKSPACE_EN
  localparam logic [6:0] CHAR_BS = 7'd8;
`endif

  state_e             state_q, state_d;
  logic [SCORE_W-1:0] acc_q, acc_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic [1:0]         count_q, count_d;

  logic               xfer;
  logic               is_digit;
  logic [6:0]         digit;

  assign char_ready  = (state_q == IDLE) || (state_q == ACCUM);
  assign xfer        = char_valid && char_ready;
  assign is_digit    = (char_code >= CHAR_0) && (char_code <= CHAR_9);
  assign digit       = char_code - CHAR_0;
  assign score       = score_q;
  assign score_valid = (state_q == DONE);
  assign parse_err   = (state_q == ERR);
  assign digit_count = count_q;

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      score_q <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      score_q <= score_d;
      count_q <= count_d;
    end
  end

  // The score is loaded on the CR edge so it is already current while score_valid is high.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    score_d = score_q;
    count_d = count_q;
    case (state_q)
      IDLE, ACCUM: begin
        if (xfer) begin
          if (is_digit) begin
            if (count_q == 2'(MAX_DIGITS)) begin
              state_d = ERR;
              acc_d   = '0;
              count_d = '0;
            end else begin
              acc_d   = acc_q * SCORE_W'(10) + SCORE_W'(digit);
              count_d = count_q + 2'd1;
              state_d = ACCUM;
            end
          end else if (char_code == CHAR_CR) begin
            state_d = (count_q != 2'd0) ? DONE : ERR;
            if (count_q != 2'd0) begin
              score_d = acc_q;
            end
            acc_d   = '0;
            count_d = '0;
          end
`ifdef ASCII_SCORE_PARSER_BACKSPACE_EN
          else if (char_code == CHAR_BS) begin
            if (count_q != 2'd0) begin
              acc_d   = acc_q / SCORE_W'(10);
              count_d = count_q - 2'd1;
              if (count_q == 2'd1) begin
                state_d = IDLE;
              end
            end
          end
`endif
          else begin
            state_d = ERR;
            acc_d   = '0;
            count_d = '0;
          end
        end
      end
      DONE, ERR: state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_ascii_score_parser.sv
// Directed self-checking bench for ascii_score_parser (default and backspace builds).
module tb_ascii_score_parser;

  logic       pclk;
  logic       rst_n;
  logic       char_valid;
  logic [6:0] char_code;
  logic       char_ready;
  logic [9:0] score;
  logic       score_valid;
  logic       parse_err;
  logic [1:0] digit_count;

  int unsigned n_assert;
  int unsigned n_fail;

  ascii_score_parser #(.MAX_DIGITS(3), .SCORE_W(10)) dut (
    .pclk        (pclk),
    .rst_n       (rst_n),
    .char_valid  (char_valid),
    .char_code   (char_code),
    .char_ready  (char_ready),
    .score       (score),
    .score_valid (score_valid),
    .parse_err   (parse_err),
    .digit_count (digit_count)
  );

  initial begin
    pclk = 1'b0;
    forever #5 pclk = ~pclk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic cycle();
    @(posedge pclk);
    #1;
  endtask

  // Waits (bounded) for char_ready, then transfers one character.
  task automatic send(input logic [6:0] c);
    int unsigned waited;
    waited = 0;
    while (!char_ready && waited < 10) begin
      cycle();
      waited++;
    end
    if (!char_ready) begin
      n_assert++;
      n_fail++;
      $display("FAIL ready_timeout: observed char_ready=0 expected 1");
    end
    char_valid = 1'b1;
    char_code  = c;
    cycle();
    char_valid = 1'b0;
    char_code  = 7'h7f;
  endtask

  initial begin
    n_assert   = 0;
    n_fail     = 0;
    rst_n      = 1'b0;
    char_valid = 1'b0;
    char_code  = 7'd0;
    #3;
    chk("rst_score", 32'(score), 0);
    chk("rst_valid", 32'(score_valid), 0);
    chk("rst_err", 32'(parse_err), 0);
    chk("rst_count", 32'(digit_count), 0);
    chk("rst_ready", 32'(char_ready), 1);
    #9 rst_n = 1'b1;
    cycle();

    // Non-transfer cycles with junk code do nothing.
    char_code = "A";
    cycle();
    cycle();
    chk("idle_noxfer_err", 32'(parse_err), 0);
    chk("idle_noxfer_cnt", 32'(digit_count), 0);

    // 1: "123"CR
    send("1"); chk("t1_cnt1", 32'(digit_count), 1);
    send("2"); chk("t1_err2", 32'(parse_err), 0);
    send("3"); chk("t1_cnt3", 32'(digit_count), 3);
    send(7'd13);
    chk("t1_valid", 32'(score_valid), 1);
    chk("t1_score", 32'(score), 123);
    chk("t1_err", 32'(parse_err), 0);
    chk("t1_ready_done", 32'(char_ready), 0);
    cycle();
    chk("t1_valid_pulse", 32'(score_valid), 0);
    chk("t1_score_held", 32'(score), 123);
    chk("t1_ready_idle", 32'(char_ready), 1);

    // 2: "007"CR
    send("0"); chk("t2_cnt1", 32'(digit_count), 1);
    send("0"); chk("t2_cnt2", 32'(digit_count), 2);
    send("7"); chk("t2_cnt3", 32'(digit_count), 3);
    send(7'd13);
    chk("t2_valid", 32'(score_valid), 1);
    chk("t2_score", 32'(score), 7);
    cycle();
    chk("t2_cnt0", 32'(digit_count), 0);

    // 3: overflow on fourth digit
    send("1"); send("2"); send("3"); send("4");
    chk("t3_err", 32'(parse_err), 1);
    chk("t3_valid", 32'(score_valid), 0);
    chk("t3_score_kept", 32'(score), 7);
    chk("t3_cnt", 32'(digit_count), 0);
    cycle();
    chk("t3_err_pulse", 32'(parse_err), 0);
    send("5"); send(7'd13);
    chk("t3_score", 32'(score), 5);
    chk("t3_valid2", 32'(score_valid), 1);

    // 4: empty entry
    send("4"); send("2"); send(7'd13);
    chk("t4_pre", 32'(score), 42);
    send(7'd13);
    chk("t4_err", 32'(parse_err), 1);
    chk("t4_valid", 32'(score_valid), 0);
    chk("t4_score", 32'(score), 42);

    // Other character mid-entry
    send("8"); send("A");
    chk("other_err", 32'(parse_err), 1);
    chk("other_score", 32'(score), 42);

    // 5: backspace
    send("4"); send("5"); send(7'd8);
`ifdef ASCII_SCORE_PARSER_BACKSPACE_EN
    chk("t5_bs_err", 32'(parse_err), 0);
    chk("t5_bs_cnt", 32'(digit_count), 1);
    send("6"); send(7'd13);
    chk("t5_score", 32'(score), 46);
    chk("t5_valid", 32'(score_valid), 1);
    cycle();
    send(7'd8);
    chk("t5_bs_empty_err", 32'(parse_err), 0);
    chk("t5_bs_empty_cnt", 32'(digit_count), 0);
    chk("t5_bs_empty_rdy", 32'(char_ready), 1);
`else
    chk("t5_bs_err", 32'(parse_err), 1);
    chk("t5_bs_cnt", 32'(digit_count), 0);
    send("6"); send(7'd13);
    chk("t5_score", 32'(score), 6);
    chk("t5_valid", 32'(score_valid), 1);
`endif

    // 6: async reset mid-entry
    send("9"); send("9");
    chk("t6_cnt", 32'(digit_count), 2);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_score", 32'(score), 0);
    chk("t6_rst_cnt", 32'(digit_count), 0);
    chk("t6_rst_ready", 32'(char_ready), 1);
    cycle();
    rst_n = 1'b1;
    cycle();
    send("1"); send(7'd13);
    chk("t6_score", 32'(score), 1);
    chk("t6_valid", 32'(score_valid), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
